// File: rtl/axi_default_slave.sv
// rtl/axi_default_slave.sv - AXI4 default/error slave terminating unmapped-address transactions
//
// Purpose: answers every AXI4 transaction routed to unmapped space with an
// error response. Writes are absorbed and answered with one B beat carrying
// RESP; reads return arlen+1 beats of RDATA_PATTERN with RESP. Up to MAX_TXNS
// accepted AW and AR requests are queued per direction. A saturating counter
// of completed transactions and the last accepted address aid software.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   aw*_i / awready_o     write address channel (only awid/awaddr are used)
//   w*_i / wready_o       write data channel (data discarded, wlast ends burst)
//   b*_o / bready_i       write response channel
//   ar*_i / arready_o     read address channel (arid/araddr/arlen used)
//   r*_o / rready_i       read data channel
//   clear_i               clears err_cnt_o and last_addr_o/last_is_write_o
//   err_cnt_o             completed erroneous transactions, saturating
//   last_addr_o           address of the most recent AW/AR handshake
//   last_is_write_o       1 when last_addr_o came from AW
module axi_default_slave #(
    parameter int          ID_WIDTH      = 4,
    parameter int          ADDR_WIDTH    = 32,
    parameter int          DATA_WIDTH    = 32,
    parameter logic [1:0]  RESP          = 2'b11,
    parameter logic [31:0] RDATA_PATTERN = 32'hBADC_AB1E,
    parameter int          MAX_TXNS      = 4,
    parameter int          CNT_WIDTH     = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    // write address
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [7:0]              awlen_i,
    input  logic [2:0]              awsize_i,
    input  logic [1:0]              awburst_i,
    input  logic [2:0]              awprot_i,
    input  logic [5:0]              awatop_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    // write data
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wlast_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    // write response
    output logic [ID_WIDTH-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    // read address
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic [7:0]              arlen_i,
    input  logic [2:0]              arsize_i,
    input  logic [1:0]              arburst_i,
    input  logic [2:0]              arprot_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    // read data
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    // diagnostics
    input  logic                    clear_i,
    output logic [CNT_WIDTH-1:0]    err_cnt_o,
    output logic [ADDR_WIDTH-1:0]   last_addr_o,
    output logic                    last_is_write_o
);

    localparam int PTR_W  = $clog2(MAX_TXNS);
    localparam int QCNT_W = PTR_W + 1;
    localparam int AR_W   = ID_WIDTH + 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_BURST}        r_state_e;

    // Attributes that an error slave has no use for.
    logic unused_inputs;
    assign unused_inputs = ^{awlen_i, awsize_i, awburst_i, awprot_i, awatop_i,
                             wdata_i, wstrb_i, arsize_i, arburst_i, arprot_i};

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic aw_hs, ar_hs, b_hs, r_hs, r_final_hs;
    logic aw_pop, ar_pop;

    assign aw_hs      = awvalid_i & awready_o;
    assign ar_hs      = arvalid_i & arready_o;
    assign b_hs       = bvalid_o & bready_i;
    assign r_hs       = rvalid_o & rready_i;
    assign r_final_hs = r_hs & rlast_o;
    assign aw_pop     = b_hs;

    // ------------------------------------------------------------------
    // AW queue: holds awid until the B response for it is accepted.
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0] aw_mem_q [MAX_TXNS];
    logic [PTR_W-1:0]    aw_wr_q, aw_rd_q;
    logic [QCNT_W-1:0]   aw_cnt_q, aw_cnt_d;
    logic                aw_full_q;

    // The full flag is registered, so ready drops only the cycle after the
    // filling push; qualifying with areset keeps ready low while in reset.
    assign awready_o = ~aw_full_q & ~areset;

    always_comb begin
        aw_cnt_d = aw_cnt_q;
        if (aw_hs && !aw_pop) begin
            aw_cnt_d = aw_cnt_q + 1'b1;
        end else if (!aw_hs && aw_pop) begin
            aw_cnt_d = aw_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_wr_q   <= '0;
            aw_rd_q   <= '0;
            aw_cnt_q  <= '0;
            aw_full_q <= 1'b0;
        end else begin
            if (aw_hs)  aw_wr_q <= aw_wr_q + 1'b1;
            if (aw_pop) aw_rd_q <= aw_rd_q + 1'b1;
            aw_cnt_q  <= aw_cnt_d;
            aw_full_q <= (aw_cnt_d == QCNT_W'(MAX_TXNS));
        end
    end

    always_ff @(posedge aclk) begin
        if (aw_hs) aw_mem_q[aw_wr_q] <= awid_i;
    end

    // ------------------------------------------------------------------
    // AR queue: holds {arid, arlen}; popped when the read FSM starts a burst.
    // ------------------------------------------------------------------
    logic [AR_W-1:0]   ar_mem_q [MAX_TXNS];
    logic [PTR_W-1:0]  ar_wr_q, ar_rd_q;
    logic [QCNT_W-1:0] ar_cnt_q, ar_cnt_d;
    logic              ar_full_q;

    assign arready_o = ~ar_full_q & ~areset;

    always_comb begin
        ar_cnt_d = ar_cnt_q;
        if (ar_hs && !ar_pop) begin
            ar_cnt_d = ar_cnt_q + 1'b1;
        end else if (!ar_hs && ar_pop) begin
            ar_cnt_d = ar_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ar_wr_q   <= '0;
            ar_rd_q   <= '0;
            ar_cnt_q  <= '0;
            ar_full_q <= 1'b0;
        end else begin
            if (ar_hs)  ar_wr_q <= ar_wr_q + 1'b1;
            if (ar_pop) ar_rd_q <= ar_rd_q + 1'b1;
            ar_cnt_q  <= ar_cnt_d;
            ar_full_q <= (ar_cnt_d == QCNT_W'(MAX_TXNS));
        end
    end

    always_ff @(posedge aclk) begin
        if (ar_hs) ar_mem_q[ar_wr_q] <= {arid_i, arlen_i};
    end

    // ------------------------------------------------------------------
    // Write FSM: serves the AW queue head; wlast alone ends the burst.
    // ------------------------------------------------------------------
    w_state_e w_state_q, w_state_d;

    always_comb begin
        w_state_d = w_state_q;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        bid_o     = '0;
        bresp_o   = RESP;
        case (w_state_q)
            W_IDLE: begin
                if (aw_cnt_q != '0) w_state_d = W_DATA;
            end
            W_DATA: begin
                wready_o = 1'b1;
                if (wvalid_i && wlast_i) w_state_d = W_RESP;
            end
            W_RESP: begin
                bvalid_o = 1'b1;
                bid_o    = aw_mem_q[aw_rd_q];
                if (bready_i) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) w_state_q <= W_IDLE;
        else        w_state_q <= w_state_d;
    end

    // ------------------------------------------------------------------
    // Read FSM: pops one AR entry per burst and streams arlen+1 beats.
    // ------------------------------------------------------------------
    r_state_e            r_state_q, r_state_d;
    logic [ID_WIDTH-1:0] rid_q;
    logic [7:0]          rcnt_q;
    logic [AR_W-1:0]     ar_head;

    assign ar_head = ar_mem_q[ar_rd_q];

    always_comb begin
        r_state_d = r_state_q;
        ar_pop    = 1'b0;
        rvalid_o  = 1'b0;
        rid_o     = '0;
        rdata_o   = '0;
        rresp_o   = RESP;
        rlast_o   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_cnt_q != '0) begin
                    ar_pop    = 1'b1;
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                rvalid_o = 1'b1;
                rid_o    = rid_q;
                rdata_o  = {(DATA_WIDTH/32){RDATA_PATTERN}};
                rlast_o  = (rcnt_q == 8'd0);
                if (rready_i && rcnt_q == 8'd0) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            rcnt_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_pop) begin
                rid_q  <= ar_head[AR_W-1:8];
                rcnt_q <= ar_head[7:0];
            end else if (r_hs && rcnt_q != 8'd0) begin
                rcnt_q <= rcnt_q - 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Diagnostics: saturating error counter and last-address capture.
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH:0]    cnt_sum;
    logic [1:0]            cnt_inc;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic                  last_wr_q, last_wr_d;

    always_comb begin
        // A B and a final R in the same cycle count as two.
        cnt_inc = {1'b0, b_hs} + {1'b0, r_final_hs};
        cnt_sum = {1'b0, err_cnt_q} + (CNT_WIDTH+1)'(cnt_inc);
        if (clear_i) begin
            err_cnt_d = '0;
        end else if (cnt_sum[CNT_WIDTH]) begin
            err_cnt_d = '1;
        end else begin
            err_cnt_d = cnt_sum[CNT_WIDTH-1:0];
        end
    end

    // AW beats AR when both handshake together; a capture beats clear_i.
    always_comb begin
        last_addr_d = last_addr_q;
        last_wr_d   = last_wr_q;
        if (aw_hs) begin
            last_addr_d = awaddr_i;
            last_wr_d   = 1'b1;
        end else if (ar_hs) begin
            last_addr_d = araddr_i;
            last_wr_d   = 1'b0;
        end else if (clear_i) begin
            last_addr_d = '0;
            last_wr_d   = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            err_cnt_q   <= '0;
            last_addr_q <= '0;
            last_wr_q   <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            last_addr_q <= last_addr_d;
            last_wr_q   <= last_wr_d;
        end
    end

    assign err_cnt_o       = err_cnt_q;
    assign last_addr_o     = last_addr_q;
    assign last_is_write_o = last_wr_q;

endmodule

// File: tb/tb_axi_default_slave.sv
// tb/tb_axi_default_slave.sv - self-checking bench for axi_default_slave
module tb_axi_default_slave;

    localparam int          IDW     = 4;
    localparam int          AW      = 32;
    localparam int          DW      = 64;
    localparam logic [1:0]  RESP    = 2'b11;
    localparam logic [31:0] PATTERN = 32'hBADC_AB1E;
    localparam int          MAXT    = 4;
    localparam int          CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;
    localparam logic [63:0] EXP_RDATA = {2{PATTERN}};

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic [IDW-1:0]  awid = '0;
    logic [AW-1:0]   awaddr = '0;
    logic [7:0]      awlen = '0;
    logic            awvalid = 1'b0, awready;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '1;
    logic            wlast = 1'b0, wvalid = 1'b0, wready;
    logic [IDW-1:0]  bid;
    logic [1:0]      bresp;
    logic            bvalid, bready = 1'b0;
    logic [IDW-1:0]  arid = '0;
    logic [AW-1:0]   araddr = '0;
    logic [7:0]      arlen = '0;
    logic            arvalid = 1'b0, arready;
    logic [IDW-1:0]  rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast, rvalid, rready = 1'b0;
    logic            clear_i = 1'b0;
    logic [CW-1:0]   err_cnt;
    logic [AW-1:0]   last_addr;
    logic            last_is_write;

    axi_default_slave #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP(RESP),
        .RDATA_PATTERN(PATTERN), .MAX_TXNS(MAXT), .CNT_WIDTH(CW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(3'd3),
        .awburst_i(2'b01), .awprot_i(3'd0), .awatop_i(6'd0),
        .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(3'd3),
        .arburst_i(2'b01), .arprot_i(3'd0), .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
        .rvalid_o(rvalid), .rready_i(rready),
        .clear_i(clear_i), .err_cnt_o(err_cnt), .last_addr_o(last_addr),
        .last_is_write_o(last_is_write)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     len;
    } ar_t;

    // Reference model: outstanding requests, burst progress, diagnostics.
    logic [IDW-1:0] aw_ids[$];
    ar_t            ar_q[$];
    int             r_beat = 0;
    bit             w_done = 0;
    int             exp_cnt = 0;
    logic [AW-1:0]  exp_addr = '0;
    logic           exp_wr = 1'b0;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int rfinal_cyc = 0;
    int arhs_cyc = 0;

    bit last_awh, last_arh, last_wh, last_bh, last_rh;
    logic s_awready, s_arready, s_wready, s_bvalid, s_rvalid;
    logic [IDW-1:0] s_bid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe and score at the falling edge, advance the model,
    // then compare the registered diagnostics just after the rising edge.
    task automatic cycle();
        bit rst_s;
        int fin;
        @(negedge aclk);
        rst_s    = areset;
        last_awh = awvalid && awready;
        last_arh = arvalid && arready;
        last_wh  = wvalid && wready;
        last_bh  = bvalid && bready;
        last_rh  = rvalid && rready;
        s_awready = awready; s_arready = arready; s_wready = wready;
        s_bvalid = bvalid; s_rvalid = rvalid; s_bid = bid;
        fin = 0;
        if (rst_s) begin
            chk("awready_in_reset", awready, 0);
            chk("arready_in_reset", arready, 0);
        end else begin
            if (wready) begin
                chk("wready_needs_aw", aw_ids.size() > 0, 1);
                chk("wready_after_wlast", w_done, 0);
            end
            if (bvalid) begin
                chk("bvalid_needs_wlast", w_done, 1);
                if (aw_ids.size() > 0) chk("bid", bid, aw_ids[0]);
                chk("bresp", bresp, RESP);
            end
            if (rvalid) begin
                if (ar_q.size() == 0) begin
                    chk("rvalid_unexpected", rvalid, 0);
                end else begin
                    chk("rid", rid, ar_q[0].id);
                    chk("rdata", rdata, EXP_RDATA);
                    chk("rresp", rresp, RESP);
                    chk("rlast", rlast, r_beat == int'(ar_q[0].len));
                end
            end
            if (last_bh) begin
                if (aw_ids.size() > 0) void'(aw_ids.pop_front());
                w_done = 0;
                fin++;
            end
            if (last_wh && wlast) w_done = 1;
            if (last_rh && ar_q.size() > 0) begin
                if (r_beat == int'(ar_q[0].len)) begin
                    void'(ar_q.pop_front());
                    r_beat = 0;
                    fin++;
                    rfinal_cyc = cyc;
                end else begin
                    r_beat++;
                end
            end
            if (last_awh) aw_ids.push_back(awid);
            if (last_arh) begin
                ar_q.push_back('{id: arid, len: arlen});
                arhs_cyc = cyc;
            end
            if (clear_i) exp_cnt = 0;
            else exp_cnt = (exp_cnt + fin > CNT_MAX) ? CNT_MAX : exp_cnt + fin;
            if (last_awh) begin
                exp_addr = awaddr; exp_wr = 1'b1;
            end else if (last_arh) begin
                exp_addr = araddr; exp_wr = 1'b0;
            end else if (clear_i) begin
                exp_addr = '0; exp_wr = 1'b0;
            end
        end
        @(posedge aclk);
        #1;
        cyc++;
        if (rst_s) begin
            aw_ids.delete(); ar_q.delete();
            r_beat = 0; w_done = 0; exp_cnt = 0; exp_addr = '0; exp_wr = 1'b0;
        end
        chk("err_cnt", err_cnt, exp_cnt);
        chk("last_addr", last_addr, exp_addr);
        chk("last_is_write", last_is_write, exp_wr);
    endtask

    task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len);
        int n;
        arid = id; araddr = a; arlen = len; arvalid = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!last_arh && n < 100);
        chk("ar_accept_timeout", last_arh, 1);
        arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [IDW-1:0] id, input logic [AW-1:0] a);
        int n;
        awid = id; awaddr = a; awvalid = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!last_awh && n < 100);
        chk("aw_accept_timeout", last_awh, 1);
        awvalid = 1'b0;
    endtask

    task automatic drain_reads(input int budget);
        int n;
        n = 0;
        while (ar_q.size() > 0 && n < budget) begin cycle(); n++; end
        chk("read_drain", ar_q.size(), 0);
    endtask

    initial begin
        int k, beats, acc, c0;

        // Reset state
        repeat (2) cycle();
        areset = 1'b0;
        cycle();
        chk("awready_after_reset", s_awready, 1);
        chk("arready_after_reset", s_arready, 1);
        chk("wready_after_reset", s_wready, 0);
        chk("bvalid_after_reset", s_bvalid, 0);
        chk("rvalid_after_reset", s_rvalid, 0);
        chk("rid_after_reset", rid, 0);
        chk("rdata_after_reset", rdata, 0);
        chk("rlast_after_reset", rlast, 0);
        chk("bid_after_reset", bid, 0);

        // Single read, first beat two cycles after the AR handshake
        rready = 1'b1;
        send_ar(4'd3, 32'h1fff_0000, 8'd0);
        k = 0;
        do begin cycle(); k++; end while (!s_rvalid && k < 10);
        chk("ar_to_rvalid_latency", k, 2);
        chk("single_read_cnt", err_cnt, 1);
        chk("single_read_addr", last_addr, 32'h1fff_0000);
        chk("single_read_is_write", last_is_write, 0);

        // W beats before any AW are stalled; then a 4-beat write, B held off
        wvalid = 1'b1;
        repeat (3) begin cycle(); chk("w_stall_before_aw", s_wready, 0); end
        send_aw(4'd5, 32'h0000_4000);
        k = 0; beats = 0;
        while (beats < 4 && k < 50) begin
            wlast = (beats == 3);
            cycle(); k++;
            if (last_wh) begin
                if (beats == 0) chk("aw_to_wready_latency", k, 2);
                beats++;
            end
        end
        chk("write_beats", beats, 4);
        wvalid = 1'b0; wlast = 1'b0;
        c0 = int'(err_cnt);
        repeat (10) begin
            cycle();
            chk("bvalid_held", s_bvalid, 1);
            chk("bid_held", s_bid, 5);
            chk("cnt_before_b", err_cnt, c0);
        end
        bready = 1'b1;
        cycle();
        chk("b_handshake", last_bh, 1);
        chk("cnt_after_b", err_cnt, c0 + 1);
        bready = 1'b0;

        // AR queue full: one entry goes straight to the FSM, MAXT more queue
        rready = 1'b0; acc = 0;
        arlen = 8'd255; araddr = 32'h0000_8000; arid = 4'd1; arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_arh) begin acc++; arid = 4'(acc + 1); end
        end
        chk("ar_accepts_when_full", acc, MAXT + 1);
        chk("arready_low_full", s_arready, 0);
        rready = 1'b1; k = 0;
        do begin cycle(); k++; end while (!last_arh && k < 400);
        chk("sixth_ar_accepted", last_arh, 1);
        chk("arready_reassert_after_burst", arhs_cyc - rfinal_cyc, 2);
        arvalid = 1'b0;
        drain_reads(2000);

        // Simultaneous AW/AR, then simultaneous final R and B
        clear_i = 1'b1; cycle(); clear_i = 1'b0;
        chk("cnt_cleared", err_cnt, 0);
        awid = 4'($urandom); awaddr = 32'h100; awvalid = 1'b1;
        arid = 4'($urandom); araddr = 32'h200; arlen = 8'd0; arvalid = 1'b1;
        rready = 1'b0;
        cycle();
        chk("dual_aw_hs", last_awh, 1);
        chk("dual_ar_hs", last_arh, 1);
        chk("dual_addr_aw_wins", last_addr, 32'h100);
        chk("dual_is_write", last_is_write, 1);
        awvalid = 1'b0; arvalid = 1'b0;
        wvalid = 1'b1; wlast = 1'b1; k = 0;
        do begin cycle(); k++; end while (!last_wh && k < 20);
        wvalid = 1'b0; k = 0;
        while (!(s_bvalid && s_rvalid) && k < 20) begin cycle(); k++; end
        bready = 1'b1; rready = 1'b1;
        cycle();
        chk("dual_b_hs", last_bh, 1);
        chk("dual_r_hs", last_rh, 1);
        chk("cnt_plus_two", err_cnt, 2);
        bready = 1'b0;

        // Saturation, then clear_i together with an increment
        for (int i = 0; i < 16; i++) begin
            send_ar(4'($urandom), $urandom, 8'($urandom_range(0, 3)));
            drain_reads(30);
        end
        chk("cnt_saturated", err_cnt, CNT_MAX);
        send_aw(4'd2, 32'h0000_0040);
        wvalid = 1'b1; wlast = 1'b1; k = 0;
        do begin cycle(); k++; end while (!last_wh && k < 20);
        wvalid = 1'b0; k = 0;
        while (!s_bvalid && k < 20) begin cycle(); k++; end
        bready = 1'b1; clear_i = 1'b1;
        cycle();
        chk("clear_with_inc_hs", last_bh, 1);
        chk("clear_beats_inc", err_cnt, 0);
        bready = 1'b0; clear_i = 1'b0;

        // Reset during beat 3 of an 8-beat burst
        rready = 1'b1;
        send_ar(4'd7, 32'h0000_3000, 8'd7);
        beats = 0; k = 0;
        while (beats < 2 && k < 20) begin cycle(); k++; if (last_rh) beats++; end
        areset = 1'b1;
        cycle();
        areset = 1'b0;
        cycle();
        chk("rvalid_after_mid_reset", s_rvalid, 0);
        chk("arready_after_mid_reset", s_arready, 1);
        chk("cnt_after_mid_reset", err_cnt, 0);
        send_ar(4'd9, 32'h0000_4000, 8'd2);
        drain_reads(30);
        chk("read_after_mid_reset", err_cnt, 1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (!awvalid || last_awh) begin
                awvalid = ($urandom_range(0, 3) == 0);
                awid = 4'($urandom); awaddr = $urandom;
            end
            if (!arvalid || last_arh) begin
                arvalid = ($urandom_range(0, 3) == 0);
                arid = 4'($urandom); araddr = $urandom; arlen = 8'($urandom_range(0, 5));
            end
            if (!wvalid || last_wh) begin
                wvalid = 1'($urandom_range(0, 1));
                wlast = ($urandom_range(0, 2) == 0);
            end
            bready = 1'($urandom_range(0, 1));
            rready = 1'($urandom_range(0, 1));
            clear_i = ($urandom_range(0, 40) == 0);
            cycle();
        end
        awvalid = 1'b0; arvalid = 1'b0; clear_i = 1'b0;
        bready = 1'b1; rready = 1'b1; wvalid = 1'b1; wlast = 1'b1;
        k = 0;
        while ((aw_ids.size() > 0 || ar_q.size() > 0) && k < 3000) begin cycle(); k++; end
        chk("random_drain", aw_ids.size() + ar_q.size(), 0);
        wvalid = 1'b0;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
